// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned 32x32->64 shift-add multiplier that
// borrows an external shared ALU for every add. The ALU add is 32 bits with
// no carry-out, so the carry of each partial-sum add is recovered by a
// second ALU pass with the unsigned set-less-than op (carry iff sum < hi).
//
// Optional build macro: ALU_MUL_ZERO_BYP_EN
//   When defined, a zero multiplicand or multiplier skips the iteration
//   and finishes in one cycle with a zero product.
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD = 4'b0010,
  parameter logic [3:0] OP_SLT = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_CARRY,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] lo, lo_nxt;
  logic [31:0] sum_r, sum_r_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        last_bit;
  logic        carry;

  assign last_bit = (cnt == 6'd31);
  assign carry    = alu_res[0];
  assign prod_hi  = hi;
  assign prod_lo  = lo;

  // State and datapath registers; reset abandons any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      sum_r <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      sum_r <= sum_r_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, datapath update and ALU/handshake outputs.
  // NOTE: every output and next value gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    hi_nxt    = hi;
    lo_nxt    = lo;
    sum_r_nxt = sum_r;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    done      = 1'b0;
    alu_in0   = '0;
    alu_in1   = '0;
    alu_op    = OP_ADD;

    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          mcand_nxt = op_a;
          hi_nxt    = '0;
          lo_nxt    = op_b;
          cnt_nxt   = '0;
          state_nxt = S_STEP;
`ifdef ALU_MUL_ZERO_BYP_EN
          if (op_a == 32'd0 || op_b == 32'd0) begin
            lo_nxt    = '0;
            state_nxt = S_DONE;
          end
`endif
        end
      end

      S_STEP: begin
        alu_in0 = hi;
        alu_in1 = mcand;
        alu_op  = OP_ADD;
        if (lo[0]) begin
          // Hold the wrapped sum; its carry is resolved next cycle.
          sum_r_nxt = alu_res;
          state_nxt = S_CARRY;
        end else begin
          hi_nxt    = {1'b0, hi[31:1]};
          lo_nxt    = {hi[0], lo[31:1]};
          cnt_nxt   = cnt + 6'd1;
          state_nxt = last_bit ? S_DONE : S_STEP;
        end
      end

      S_CARRY: begin
        alu_in0   = sum_r;
        alu_in1   = hi;
        alu_op    = OP_SLT;
        hi_nxt    = {carry, sum_r[31:1]};
        lo_nxt    = {sum_r[0], lo[31:1]};
        cnt_nxt   = cnt + 6'd1;
        state_nxt = last_bit ? S_DONE : S_STEP;
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed plus random operations on alu_mul_seq, with the
// shared ALU modelled here and results/latencies predicted from plain
// 64-bit arithmetic and bit counting.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        ready, done;
  logic [31:0] prod_hi, prod_lo;
  logic [31:0] alu_in0, alu_in1;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] prev_prod = '0;

  alu_mul_seq #(.OP_ADD(OP_ADD), .OP_SLT(OP_SLT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .ready   (ready),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo),
    .alu_in0 (alu_in0),
    .alu_in1 (alu_in1),
    .alu_op  (alu_op),
    .alu_res (alu_res)
  );

  always #5 clk = ~clk;

  // Shared ALU: 32-bit wrapping add and unsigned set-less-than.
  always_comb begin
    if (alu_op == OP_ADD)      alu_res = alu_in0 + alu_in1;
    else if (alu_op == OP_SLT) alu_res = {31'b0, (alu_in0 < alu_in1)};
    else                       alu_res = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The opcode must always be a decoded value.
  always @(negedge clk) begin
    if (rst === 1'b0)
      check("alu_op_legal", 64'(alu_op == OP_ADD || alu_op == OP_SLT), 64'd1);
  end

  function automatic int model_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MUL_ZERO_BYP_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 33 + $countones(b);
  endfunction

  // One operation: raise start in the next idle cycle, count cycles to done.
  // glitch_at > 0 re-raises start with junk operands that many cycles in.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int glitch_at, input string name);
    logic [63:0] exp_prod;
    int          lat, n;
    bit          seen, ready_low;
    exp_prod = {32'b0, a} * {32'b0, b};
    lat      = model_latency(a, b);
    @(negedge clk);
    check({name, ":ready_idle"}, 64'(ready), 64'd1);
    check({name, ":hold_prev"}, {prod_hi, prod_lo}, prev_prod);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    n = 0; seen = 1'b0; ready_low = 1'b1;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == glitch_at);
      op_a  = start ? $urandom : ~a;
      op_b  = start ? $urandom : ~b;
      if (done === 1'b1) seen = 1'b1;
      else if (ready !== 1'b0) ready_low = 1'b0;
    end
    start = 1'b0;
    check({name, ":latency"}, 64'(n), 64'(lat));
    check({name, ":ready_busy"}, 64'(ready_low), 64'd1);
    check({name, ":ready_at_done"}, 64'(ready), 64'd0);
    check({name, ":product"}, {prod_hi, prod_lo}, exp_prod);
    prev_prod = exp_prod;
  endtask

  initial begin
    bit done_seen;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("rst:ready", 64'(ready), 64'd1);
    check("rst:done", 64'(done), 64'd0);
    check("rst:prod", {prod_hi, prod_lo}, 64'd0);
    rst = 1'b0;

    run_op(32'd5, 32'd3, 0, "five_x_three");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "all_ones");
    run_op(32'h8000_0000, 32'h8000_0000, 0, "msb_x_msb");
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 10, "mid_start_ignored");
    // The following start lands in the cycle right after done.
    run_op(32'hCAFE_F00D, 32'h0000_0001, 0, "b2b_after_done");

    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, (i % 2 == 0) ? 7 : 0, $sformatf("rand%0d", i));

    // Reset 10 cycles into an operation: abandon it, clear outputs at once.
    @(negedge clk);
    op_a = 32'h0BAD_CAFE; op_b = 32'hFFFF_0000; start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst:ready", 64'(ready), 64'd1);
    check("midrst:done", 64'(done), 64'd0);
    check("midrst:prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_prod = '0;
    done_seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen = 1'b1;
    end
    check("midrst:no_done", 64'(done_seen), 64'd0);
    run_op(32'h0001_0003, 32'h0000_0007, 0, "after_rst");

    run_op(32'd0, 32'h0000_1234, 0, "zero_a");
    run_op(32'h0000_1234, 32'd0, 0, "zero_b");
    run_op($urandom, $urandom, 0, "rand_last");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
